// File: rtl/hs_data_sync.sv
// hs_data_sync: single-word clock-domain crossing using a req/ack handshake (two- or four-phase) around a stable holding register
// Ports: src_clk/src_rst_n source clock and async active-low reset; src_valid/src_ready/src_data source handshake;
//        src_busy high while a word is in flight; dst_clk/dst_rst_n destination clock and async active-low reset;
//        dst_valid/dst_ready/dst_data destination handshake.
module hs_data_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FOUR_PHASE  = 0
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic             dst_clk,
  input  logic             dst_rst_n,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_busy,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] dst_data
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam bit FP = FOUR_PHASE != 0;
  logic [1:0]             state;
  logic                   req;
  logic                   ack;
  logic [WIDTH-1:0]       hold;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   ack_s;
  logic                   req_s;
  logic                   req_d;
  logic                   accept;
  logic                   new_word;
  logic                   req_fall;
  logic                   consume;
  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign req_s     = req_sync[SYNC_STAGES-1];
  assign src_ready = state == IDLE;
  assign src_busy  = ~src_ready;
  assign accept    = src_valid & src_ready;
  assign new_word  = FP ? req_s & ~req_d : req_s ^ req_d;
  assign req_fall  = ~req_s & req_d;
  assign consume   = dst_valid & dst_ready;
  // hold only loads in IDLE, so it is stable whenever the destination samples it
  always_ff @(posedge src_clk or negedge src_rst_n)
    if (!src_rst_n) begin
      state    <= IDLE;
      req      <= 1'b0;
      hold     <= '0;
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
      if (accept) begin
        hold  <= src_data;
        req   <= FP ? 1'b1 : ~req;
        state <= REQ;
      end else if (state == REQ && (FP ? ack_s : ack_s == req)) begin
        req   <= FP ? 1'b0 : req;
        state <= FP ? RELEASE : IDLE;
      end else if (state == RELEASE && !ack_s) begin
        state <= IDLE;
      end
    end
  always_ff @(posedge dst_clk or negedge dst_rst_n)
    if (!dst_rst_n) begin
      req_sync  <= '0;
      req_d     <= 1'b0;
      dst_valid <= 1'b0;
      dst_data  <= '0;
      ack       <= 1'b0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req};
      req_d    <= req_s;
      if (new_word) begin
        dst_valid <= 1'b1;
        dst_data  <= hold;
      end else if (consume) begin
        dst_valid <= 1'b0;
      end
      if (consume) ack <= FP ? 1'b1 : ~ack;
      else if (FP && req_fall) ack <= 1'b0;
    end
endmodule
